// File: rtl/mem_port_arbiter.sv
// Purpose : shares one unified Memory port between instruction fetch (IF) and load/store (D).
// Latency : request seen in cycle 0 -> ack in cycle MEM_LAT+1; one grant per MEM_LAT+2 cycles.
// Backpr. : requesters hold req/fields stable until their one-cycle ack; only IDLE samples requests.
// Optional feature: define ARB_FAIRNESS_EN to bound how many D grants may pass a waiting IF.
module mem_port_arbiter #(
    parameter int MEM_LAT     = 1,
    parameter int MAX_DSTREAK = 4,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_mode,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [2:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Down-counter only needs to hold MEM_LAT-1.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

    state_t          state_q;
    logic            owner_d_q;     // 1: current access belongs to D, 0: to IF
    logic            illegal_q;     // current D access had an illegal mode
    logic [CW-1:0]   lat_cnt_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic [2:0]      mem_mode_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic            if_ack_q;
    logic [31:0]     if_rdata_q;
    logic            d_ack_q;
    logic [31:0]     d_rdata_q;
    logic            d_err_q;
    logic            busy_q;

    logic            d_legal_d;
    logic            force_if_d;
    logic            grant_d_d;
    logic            grant_if_d;

    // Stores support W/HU/BU encodings only; loads support everything up to B signed.
    always_comb begin
        d_legal_d = 1'b0;
        if (d_we) begin
            d_legal_d = (d_mode <= 3'b010);
        end else begin
            d_legal_d = (d_mode <= 3'b100);
        end
    end

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    logic [SW-1:0] streak_q;

    // Once D has passed a waiting IF MAX_DSTREAK times, IF takes the next slot.
    assign force_if_d = if_req && (streak_q >= SW'(MAX_DSTREAK));

    // Count D grants made over a waiting IF; any IF grant or idle IF clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else if (state_q == IDLE) begin
            if (!if_req || grant_if_d) begin
                streak_q <= '0;
            end else if (grant_d_d) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end
`else
    // Strict D priority: IF may starve while D keeps requesting.
    assign force_if_d = 1'b0;
`endif

    // D normally wins a collision because a load/store stalls the pipe longer than a fetch.
    always_comb begin
        grant_d_d  = 1'b0;
        grant_if_d = 1'b0;
        if (d_req && !force_if_d) begin
            grant_d_d = 1'b1;
        end else if (if_req) begin
            grant_if_d = 1'b1;
        end
    end

    // Access sequencer: grant in IDLE, hold strobes MEM_LAT cycles, ack in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            illegal_q   <= 1'b0;
            lat_cnt_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_mode_q  <= 3'b000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Acks and error flag are single-cycle pulses.
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d_d) begin
                        owner_d_q   <= 1'b1;
                        illegal_q   <= ~d_legal_d;
                        mem_addr_q  <= d_addr;
                        mem_mode_q  <= d_mode;
                        mem_wdata_q <= d_wdata;
                        // An illegal request still walks the FSM but never touches Memory.
                        mem_read_q  <= ~d_we & d_legal_d;
                        mem_write_q <= d_we & d_legal_d;
                        lat_cnt_q   <= LAT_LOAD;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end else if (grant_if_d) begin
                        owner_d_q   <= 1'b0;
                        illegal_q   <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_mode_q  <= 3'b000;
                        mem_wdata_q <= '0;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        lat_cnt_q   <= LAT_LOAD;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt_q == '0) begin
                        // Last strobe cycle: capture read data for the owner only.
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                        if (owner_d_q) begin
                            d_ack_q   <= 1'b1;
                            d_err_q   <= illegal_q;
                            d_rdata_q <= illegal_q ? 32'h0 : mem_rdata;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_mode  = mem_mode_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
